// File: rtl/ex_pkg.sv
// Shared types for the execute stage: operation codes, mul/div FSM states, default widths.
// Seventeen operations do not fit a 4-bit code, so ex_op_t is 5 bits wide.
package ex_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int MUL_LAT_DEF = 4;
  localparam int OP_W        = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_NOR   = 5'd5,
    OP_SLT   = 5'd6,
    OP_SLTU  = 5'd7,
    OP_SLL   = 5'd8,
    OP_SRL   = 5'd9,
    OP_SRA   = 5'd10,
    OP_MULT  = 5'd11,
    OP_MULTU = 5'd12,
    OP_DIV   = 5'd13,
    OP_DIVU  = 5'd14,
    OP_MFHI  = 5'd15,
    OP_MFLO  = 5'd16
  } ex_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input ex_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: fixed-latency multiply, restoring divide
// on operand magnitudes with a sign fix applied on the last iteration.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              abort,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output md_state_t         state
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic [2*DATA_W-1:0] ext_a, ext_b;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [DATA_W:0]     shifted;
  logic                ge;
  logic [DATA_W-1:0]   step_rem, step_quo, q_fix, r_fix;

  always_comb begin
    ext_a    = {{DATA_W{is_signed & a[DATA_W-1]}}, a};
    ext_b    = {{DATA_W{is_signed & b[DATA_W-1]}}, b};
    a_abs    = (is_signed & a[DATA_W-1]) ? -a : a;
    b_abs    = (is_signed & b[DATA_W-1]) ? -b : b;
    shifted  = {rem_q, quo_q[DATA_W-1]};
    ge       = shifted >= {1'b0, dvs_q};
    step_rem = ge ? DATA_W'(shifted - {1'b0, dvs_q}) : shifted[DATA_W-1:0];
    step_quo = {quo_q[DATA_W-2:0], ge};
    q_fix    = neg_quo_q ? -step_quo : step_quo;
    r_fix    = neg_rem_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (is_div) begin
            state_d   = MD_DIV;
            cnt_d     = CNT_W'(DATA_W - 1);
            rem_d     = '0;
            quo_d     = a_abs;
            dvs_d     = b_abs;
            // A zero divisor keeps the all-ones quotient unsigned; the remainder path
            // then naturally rebuilds the original dividend.
            neg_quo_d = is_signed & (a[DATA_W-1] ^ b[DATA_W-1]) & (|b);
            neg_rem_d = is_signed & a[DATA_W-1];
          end else begin
            state_d = MD_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
            prod_d  = ext_a * ext_b;
          end
        end
      end
      MD_MUL: begin
        if (cnt_q == '0) begin
          state_d      = MD_IDLE;
          {hi_d, lo_d} = prod_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          hi_d    = r_fix;
          lo_d    = q_fix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    if (abort) begin
      state_d = MD_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q != MD_IDLE);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign state = state_q;

endmodule

// File: rtl/ex_stage_muldiv.sv
// MIPS execute stage: single-cycle ALU, branch-target adder, operand/destination muxes,
// EX/MEM output register and the iterative mul/div unit with HI/LO.
module ex_stage_muldiv
  import ex_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              stall_in,
  output logic              stall_o,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  ex_op_t            op,
  input  logic [DATA_W-1:0] PCAddResult,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] SignExtResult,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  output logic              valid_o,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              Branch_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic [DATA_W-1:0] ALUAddResult,
  output logic [DATA_W-1:0] ReadData2_out,
  output logic [REG_AW-1:0] dest_reg,
  output md_state_t         dbg_state,
  output logic [DATA_W-1:0] dbg_hi,
  output logic [DATA_W-1:0] dbg_lo
);

  localparam int OUT_W = 7 + 3 * DATA_W + REG_AW;

  logic [DATA_W-1:0] alu_b, alu_res, branch_sum, md_hi, md_lo;
  logic [4:0]        shamt;
  logic              md_busy, is_md, accept;
  logic [OUT_W-1:0]  exmem_q, exmem_d, load_v, bubble_v;

  // Handshake: ID/EX offers an instruction with in_valid; it is taken on a rising edge
  // only when stall_o is low and flush is low. While stall_o is high upstream must hold.
  assign stall_o = md_busy | stall_in;
  assign is_md   = is_muldiv(op);
  assign accept  = in_valid & ~stall_o & ~flush;

  always_comb begin
    alu_b      = ALUSrc ? SignExtResult : ReadData2;
    shamt      = SignExtResult[10:6];
    branch_sum = PCAddResult + {SignExtResult[DATA_W-3:0], 2'b00};
    alu_res    = '0;
    case (op)
      OP_ADD:  alu_res = ReadData1 + alu_b;
      OP_SUB:  alu_res = ReadData1 - alu_b;
      OP_AND:  alu_res = ReadData1 & alu_b;
      OP_OR:   alu_res = ReadData1 | alu_b;
      OP_XOR:  alu_res = ReadData1 ^ alu_b;
      OP_NOR:  alu_res = ~(ReadData1 | alu_b);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(ReadData1) < $signed(alu_b)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, ReadData1 < alu_b};
      OP_SLL:  alu_res = alu_b << shamt;
      OP_SRL:  alu_res = alu_b >> shamt;
      OP_SRA:  alu_res = $signed(alu_b) >>> shamt;
      OP_MFHI: alu_res = md_hi;
      OP_MFLO: alu_res = md_lo;
      default: alu_res = '0;
    endcase
  end

  // Bubbles carry a zero result, so their Zero flag reads 1.
  always_comb begin
    bubble_v = {6'b0, {DATA_W{1'b0}}, 1'b1, {(2*DATA_W+REG_AW){1'b0}}};
    load_v   = {1'b1, RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in,
                alu_res, (alu_res == '0), branch_sum, ReadData2, RegDst ? rd : rt};
    exmem_d  = exmem_q;
    if (flush) begin
      exmem_d = bubble_v;
    end else if (stall_in) begin
      exmem_d = exmem_q;
    end else if (accept && !is_md) begin
      exmem_d = load_v;
    end else begin
      exmem_d = bubble_v;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) exmem_q <= '0;
    else      exmem_q <= exmem_d;
  end

  assign {valid_o, RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out,
          ALUResult, Zero, ALUAddResult, ReadData2_out, dest_reg} = exmem_q;

  ex_muldiv_unit #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_muldiv (
    .clk       (Clk),
    .rst_n     (Rst),
    .start     (accept & is_md),
    .is_div    ((op == OP_DIV) || (op == OP_DIVU)),
    .is_signed ((op == OP_MULT) || (op == OP_DIV)),
    .a         (ReadData1),
    .b         (alu_b),
    .abort     (flush),
    .busy      (md_busy),
    .hi        (md_hi),
    .lo        (md_lo),
    .state     (dbg_state)
  );

  assign dbg_hi = md_hi;
  assign dbg_lo = md_lo;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Bench for ex_stage_muldiv: directed spec cases plus randomized traffic checked against
// an arithmetic reference model of the stage and of HI/LO.
module tb_ex_stage_muldiv;
  import ex_pkg::*;

  localparam int W  = 32;
  localparam int RA = 5;
  localparam int ML = 4;

  typedef struct packed {
    logic          valid;
    logic [4:0]    ctl;
    logic [W-1:0]  res;
    logic          zero;
    logic [W-1:0]  badd;
    logic [W-1:0]  sd;
    logic [RA-1:0] dest;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, stall_in = 1'b0, stall_o;
  logic RegWrite_in = 1'b0, MemtoReg_in = 1'b0, Branch_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
  logic RegDst = 1'b0, ALUSrc = 1'b0;
  ex_op_t op = OP_ADD;
  logic [W-1:0] PCAddResult = '0, ReadData1 = '0, ReadData2 = '0, SignExtResult = '0;
  logic [RA-1:0] rt = '0, rd = '0;
  logic valid_o, RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Zero;
  logic [W-1:0] ALUResult, ALUAddResult, ReadData2_out, dbg_hi, dbg_lo;
  logic [RA-1:0] dest_reg;
  md_state_t dbg_state;

  int total = 0;
  int bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] exp_q[$];

  always #5 Clk = ~Clk;

  ex_stage_muldiv #(.DATA_W(W), .REG_AW(RA), .MUL_LAT(ML)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .flush(flush), .stall_in(stall_in),
    .stall_o(stall_o), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .op(op), .PCAddResult(PCAddResult),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExtResult(SignExtResult),
    .rt(rt), .rd(rd), .valid_o(valid_o), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .Branch_out(Branch_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .ALUResult(ALUResult), .Zero(Zero),
    .ALUAddResult(ALUAddResult), .ReadData2_out(ReadData2_out), .dest_reg(dest_reg),
    .dbg_state(dbg_state), .dbg_hi(dbg_hi), .dbg_lo(dbg_lo)
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(ex_op_t o, logic [W-1:0] a, logic [W-1:0] b, int sh);
    logic [W-1:0] ones;
    ones = '1;
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return (int'(a) < int'(b)) ? 1 : 0;
      OP_SLTU: return (a < b) ? 1 : 0;
      OP_SLL:  return a * 0 + (b << sh);
      OP_SRL:  return b >> sh;
      OP_SRA:  return (b >> sh) | (b[W-1] ? ~(ones >> sh) : '0);
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return '0;
    endcase
  endfunction

  task automatic ref_md(input ex_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint p;
    longint unsigned pu;
    int sa, sb;
    hi = '0; lo = '0;
    if (o == OP_MULT) begin
      p = longint'(int'(a)) * longint'(int'(b));
      hi = p[63:32]; lo = p[31:0];
    end else if (o == OP_MULTU) begin
      pu = {32'b0, a} * {32'b0, b};
      hi = pu[63:32]; lo = pu[31:0];
    end else if (b == 0) begin
      lo = '1; hi = a;
    end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000; hi = '0;
    end else if (o == OP_DIV) begin
      sa = a; sb = b;
      lo = sa / sb; hi = sa % sb;
    end else begin
      lo = a / b; hi = a % b;
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    e.zero = 1'b1;
    return e;
  endfunction

  function automatic exp_t model_accept();
    exp_t e;
    logic [W-1:0] b;
    b = ALUSrc ? SignExtResult : ReadData2;
    if (is_muldiv(op)) return bubble();
    e.valid = 1'b1;
    e.ctl   = {RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in};
    e.res   = ref_alu(op, ReadData1, b, int'(SignExtResult[10:6]));
    e.zero  = (e.res == 0);
    e.badd  = PCAddResult + SignExtResult * 4;
    e.sd    = ReadData2;
    e.dest  = RegDst ? rd : rt;
    return e;
  endfunction

  function automatic exp_t sample();
    return {valid_o, RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out,
            ALUResult, Zero, ALUAddResult, ReadData2_out, dest_reg};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input ex_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input logic [W-1:0] pc, input logic alusrc,
                       input logic regdst, input logic [RA-1:0] t, input logic [RA-1:0] d,
                       input logic [4:0] ctl);
    op = o; ReadData1 = a; ReadData2 = b; SignExtResult = imm; PCAddResult = pc;
    ALUSrc = alusrc; RegDst = regdst; rt = t; rd = d;
    {RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in} = ctl;
    in_valid = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if (sample() !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", sample()); end
    total++;
    if (dbg_hi !== '0 || dbg_lo !== '0) begin
      bad++; $display("FAIL reset_hilo got hi=%h lo=%h want 0", dbg_hi, dbg_lo);
    end
    total++;
    if (dbg_state !== MD_IDLE || stall_o !== 1'b0) begin
      bad++; $display("FAIL reset_fsm got state=%0d stall_o=%b want 0/0", dbg_state, stall_o);
    end
    #3 Rst = 1'b1;
  endtask

  task automatic test_directed();
    drive(OP_ADD, 32'd7, 32'hFFFF_FFFD, '0, '0, 1'b0, 1'b1, 5'd3, 5'd9, 5'b10000);
    tick();
    total++;
    if (ALUResult !== 32'd4 || dest_reg !== 5'd9 || valid_o !== 1'b1 || Zero !== 1'b0 || RegWrite_out !== 1'b1) begin
      bad++; $display("FAIL add_basic got res=%h dest=%0d v=%b z=%b rw=%b want 4/9/1/0/1",
                      ALUResult, dest_reg, valid_o, Zero, RegWrite_out);
    end
    drive(OP_SUB, 32'd5, 32'd5, 32'd3, 32'h100, 1'b0, 1'b0, 5'd4, 5'd0, 5'b00100);
    tick();
    total++;
    if (ALUResult !== 32'd0 || Zero !== 1'b1 || ALUAddResult !== 32'h10C || Branch_out !== 1'b1 || dest_reg !== 5'd4) begin
      bad++; $display("FAIL beq_sub got res=%h z=%b badd=%h br=%b dest=%0d want 0/1/10c/1/4",
                      ALUResult, Zero, ALUAddResult, Branch_out, dest_reg);
    end
    drive(OP_SRA, '0, 32'h8000_0010, 32'h0000_0100, '0, 1'b0, 1'b1, 5'd1, 5'd2, 5'b10000);
    tick();
    total++;
    if (ALUResult !== 32'hF800_0001) begin
      bad++; $display("FAIL sra_shamt got=%h want=f8000001", ALUResult);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (sample() !== bubble()) begin bad++; $display("FAIL idle_bubble got=%h want=%h", sample(), bubble()); end
  endtask

  task automatic test_stall_in();
    exp_t frozen;
    drive(OP_ADD, 32'd1, 32'd2, 32'h40, 32'h200, 1'b0, 1'b1, 5'd1, 5'd7, 5'b11000);
    frozen = model_accept();
    tick();
    total++;
    if (sample() !== frozen) begin bad++; $display("FAIL stall_load got=%h want=%h", sample(), frozen); end
    drive(OP_SUB, 32'd9, 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 5'd2, 5'd3, 5'b00001);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stall_o !== 1'b1) begin bad++; $display("FAIL stall_o_follow[%0d] got=%b want=1", i, stall_o); end
      tick();
      total++;
      if (sample() !== frozen) begin bad++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, sample(), frozen); end
    end
    stall_in = 1'b0;
    in_valid = 1'b0;
    tick();
    total++;
    if (sample() !== bubble()) begin bad++; $display("FAIL stall_release got=%h want=%h", sample(), bubble()); end
  endtask

  task automatic test_muldiv();
    ex_op_t d_op[7] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
    logic [W-1:0] d_a[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [W-1:0] d_b[7]  = '{32'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] d_hi[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0, 32'hFFFF_FFFB};
    logic [W-1:0] d_lo[7] = '{32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    ex_op_t r_op[4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    ex_op_t o;
    logic [W-1:0] a, b, eh, el;
    int cnt, lat;
    for (int i = 0; i < 15; i++) begin
      if (i < 7) begin
        o = d_op[i]; a = d_a[i]; b = d_b[i]; eh = d_hi[i]; el = d_lo[i];
      end else begin
        o = r_op[$urandom_range(0, 3)];
        a = $urandom;
        b = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
        ref_md(o, a, b, eh, el);
      end
      lat = (o == OP_MULT || o == OP_MULTU) ? ML : W;
      drive(o, a, b, '0, '0, 1'b0, 1'b1, 5'd1, 5'd2, 5'b10000);
      tick();
      total++;
      if (valid_o !== 1'b0 || RegWrite_out !== 1'b0 || stall_o !== 1'b1) begin
        bad++; $display("FAIL md_accept[%0d] got v=%b rw=%b stall=%b want 0/0/1", i, valid_o, RegWrite_out, stall_o);
      end
      // an ALU op waiting behind the busy unit must not issue
      drive(OP_ADD, 32'd1, 32'd1, '0, '0, 1'b0, 1'b1, 5'd1, 5'd2, 5'b10000);
      cnt = 0;
      while (stall_o === 1'b1 && cnt < 100) begin
        tick();
        cnt++;
      end
      in_valid = 1'b0;
      total++;
      if (cnt != lat || valid_o !== 1'b0) begin
        bad++; $display("FAIL md_latency[%0d] got cycles=%0d v=%b want %0d/0", i, cnt, valid_o, lat);
      end
      total++;
      if (dbg_hi !== eh || dbg_lo !== el) begin
        bad++; $display("FAIL md_hilo[%0d] op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                        i, o, a, b, dbg_hi, dbg_lo, eh, el);
      end
      m_hi = eh; m_lo = el;
      exp_q.push_back(el);
      exp_q.push_back(eh);
      drive(OP_MFLO, '0, '0, '0, '0, 1'b0, 1'b1, 5'd0, 5'd5, 5'b10000);
      tick();
      el = exp_q.pop_front();
      total++;
      if (ALUResult !== el || valid_o !== 1'b1) begin
        bad++; $display("FAIL mflo[%0d] got=%h v=%b want=%h", i, ALUResult, valid_o, el);
      end
      drive(OP_MFHI, '0, '0, '0, '0, 1'b0, 1'b1, 5'd0, 5'd6, 5'b10000);
      tick();
      eh = exp_q.pop_front();
      total++;
      if (ALUResult !== eh) begin bad++; $display("FAIL mfhi[%0d] got=%h want=%h", i, ALUResult, eh); end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_random_alu();
    ex_op_t ops[13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
                        OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO};
    exp_t e;
    logic [W-1:0] a;
    in_valid = 1'b0; flush = 1'b0; stall_in = 1'b0;
    tick();
    e = bubble();
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      drive(ops[$urandom_range(0, 12)], a, ($urandom_range(0, 3) == 0) ? a : $urandom,
            $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom), 5'($urandom), 5'($urandom));
      in_valid = ($urandom_range(0, 4) != 0);
      stall_in = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (stall_o !== stall_in) begin bad++; $display("FAIL rand_stall_o[%0d] got=%b want=%b", i, stall_o, stall_in); end
      if (flush) e = bubble();
      else if (stall_in) e = e;
      else if (in_valid) e = model_accept();
      else e = bubble();
      tick();
      total++;
      if (sample() !== e) begin bad++; $display("FAIL rand_out[%0d] op=%0d got=%h want=%h", i, op, sample(), e); end
    end
    in_valid = 1'b0; flush = 1'b0; stall_in = 1'b0;
  endtask

  task automatic test_flush();
    drive(OP_ADD, 32'd3, 32'd4, '0, '0, 1'b0, 1'b1, 5'd1, 5'd2, 5'b10000);
    flush = 1'b1;
    tick();
    total++;
    if (sample() !== bubble()) begin bad++; $display("FAIL flush_idle got=%h want=%h", sample(), bubble()); end
    flush = 1'b0;
    tick();
    stall_in = 1'b1;
    flush = 1'b1;
    tick();
    total++;
    if (valid_o !== 1'b0 || RegWrite_out !== 1'b0) begin
      bad++; $display("FAIL flush_over_stall got v=%b rw=%b want 0/0", valid_o, RegWrite_out);
    end
    flush = 1'b0; stall_in = 1'b0;
    drive(OP_DIV, 32'd100, 32'd7, '0, '0, 1'b0, 1'b1, 5'd1, 5'd2, 5'b10000);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (dbg_state !== MD_IDLE || stall_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL flush_div_abort got state=%0d stall=%b v=%b want 0/0/0", dbg_state, stall_o, valid_o);
    end
    total++;
    if (dbg_hi !== m_hi || dbg_lo !== m_lo) begin
      bad++; $display("FAIL flush_div_hilo got hi=%h lo=%h want hi=%h lo=%h", dbg_hi, dbg_lo, m_hi, m_lo);
    end
    drive(OP_MFLO, '0, '0, '0, '0, 1'b0, 1'b1, 5'd0, 5'd5, 5'b10000);
    tick();
    in_valid = 1'b0;
    total++;
    if (ALUResult !== m_lo) begin bad++; $display("FAIL flush_mflo got=%h want=%h", ALUResult, m_lo); end
  endtask

  task automatic test_reset_mid_div();
    drive(OP_DIVU, 32'hDEAD_BEEF, 32'd3, '0, '0, 1'b0, 1'b1, 5'd1, 5'd2, 5'b10000);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 Rst = 1'b0;
    #1;
    total++;
    if (sample() !== '0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_div_out got=%h stall=%b want 0/0", sample(), stall_o);
    end
    total++;
    if (dbg_hi !== '0 || dbg_lo !== '0 || dbg_state !== MD_IDLE) begin
      bad++; $display("FAIL rst_mid_div_hilo got hi=%h lo=%h state=%0d want 0/0/0", dbg_hi, dbg_lo, dbg_state);
    end
    m_hi = '0; m_lo = '0;
    tick();
    #2 Rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_in();
    test_muldiv();
    test_random_alu();
    test_flush();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
